// File: rtl/crc16_usb_pkg.sv
// Shared constants and FSM state encoding for the USB CRC16 packet sequencer.
package crc16_usb_pkg;

  localparam logic [15:0] CRC16_USB_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_USB_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_USB_XOROUT    = 16'hFFFF;
  localparam logic [15:0] CRC16_USB_RESIDUE   = 16'hB001;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    EMIT,
    WAIT,
    CRC_LO,
    CRC_HI
  } pkt_state_t;

endpackage

// File: rtl/crc16_usb_step.sv
// One bit step of the reflected USB CRC16 (x^16+x^15+x^2+1); passes crc through when en=0.
module crc16_usb_step
  import crc16_usb_pkg::*;
(
  input  logic [15:0] crc,
  input  logic        din,
  input  logic        en,
  output logic [15:0] crc_next
);

  logic fb;

  assign fb = din ^ crc[0];

  always_comb begin
    crc_next = crc;
    if (en) begin
      crc_next = (crc >> 1) ^ (fb ? CRC16_USB_POLY_REFL : 16'h0000);
    end
  end

endmodule

// File: rtl/crc16_usb_pkt_ctrl.sv
// Packet sequencer: shifts each byte LSB-first through the CRC, forwards it,
// then appends the CRC (TX) or checks the residue (RX).
//   state  | meaning
//   IDLE   | no packet; first byte starts a packet and reinitialises the CRC
//   SHIFT  | feeding latched byte into the CRC, one bit per cycle
//   EMIT   | presenting latched byte downstream
//   WAIT   | mid-packet, waiting for the next input byte
//   CRC_LO | TX: presenting low CRC byte
//   CRC_HI | TX: presenting high CRC byte (last of packet)
module crc16_usb_pkt_ctrl
  import crc16_usb_pkg::*;
#(
  parameter logic [15:0] CRC_INIT    = CRC16_USB_INIT,
  parameter logic [15:0] CRC_XOROUT  = CRC16_USB_XOROUT,
  parameter logic [15:0] CRC_RESIDUE = CRC16_USB_RESIDUE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mode_rx,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic [15:0] crc_o,
  output logic        busy,
  output logic        done,
  output logic        crc_err
);

  pkt_state_t  state_q, state_d;
  logic [7:0]  byte_q;
  logic        last_q;
  logic        mode_q;
  logic [2:0]  cnt_q;
  logic [15:0] crc_q;
  logic [15:0] crc_next;
  logic [15:0] crc_out;
  logic        done_q;
  logic        err_q;
  logic        accept;
  logic        pkt_end;
  logic        end_err;

  crc16_usb_step u_step (
    .crc      (crc_q),
    .din      (byte_q[cnt_q]),
    .en       (state_q == SHIFT),
    .crc_next (crc_next)
  );

  assign crc_out = crc_q ^ CRC_XOROUT;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    accept    = 1'b0;
    pkt_end   = 1'b0;
    end_err   = 1'b0;
    case (state_q)
      IDLE, WAIT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == 3'd7) state_d = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        out_data  = byte_q;
        out_last  = last_q & mode_q;
        if (out_ready) begin
          if (!last_q) begin
            state_d = WAIT;
          end else if (!mode_q) begin
            state_d = CRC_LO;
          end else begin
            state_d = IDLE;
            pkt_end = 1'b1;
            end_err = (crc_q != CRC_RESIDUE);
          end
        end
      end
      CRC_LO: begin
        out_valid = 1'b1;
        out_data  = crc_out[7:0];
        if (out_ready) state_d = CRC_HI;
      end
      CRC_HI: begin
        out_valid = 1'b1;
        out_data  = crc_out[15:8];
        out_last  = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
          pkt_end = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Mode and CRC seed are taken only on a packet's first byte (accept from IDLE).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      byte_q  <= 8'h00;
      last_q  <= 1'b0;
      mode_q  <= 1'b0;
      cnt_q   <= 3'd0;
      crc_q   <= CRC_INIT;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= pkt_end;
      err_q   <= end_err;
      if (accept) begin
        byte_q <= in_data;
        last_q <= in_last;
        cnt_q  <= 3'd0;
        if (state_q == IDLE) begin
          mode_q <= mode_rx;
          crc_q  <= CRC_INIT;
        end
      end
      if (state_q == SHIFT) begin
        crc_q <= crc_next;
        cnt_q <= cnt_q + 3'd1;
      end
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign crc_err = err_q;
  assign crc_o   = crc_q;

endmodule

// File: tb/tb_crc16_usb_pkt_ctrl.sv
// Directed bench for the USB CRC16 packet sequencer with hand-computed expected bytes.
module tb_crc16_usb_pkt_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode_rx;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [15:0] crc_o;
  logic        busy;
  logic        done;
  logic        crc_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  cap_data [$];
  logic        cap_last [$];
  int          done_cnt = 0;
  logic        err_at_done = 1'b0;
  logic [15:0] crc_at_done = 16'h0000;

  // "123456789" followed by its USB CRC16 0xB4C8, low byte first
  logic [7:0] msg [0:10] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                             8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};

  crc16_usb_pkt_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .mode_rx   (mode_rx),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .crc_o     (crc_o),
    .busy      (busy),
    .done      (done),
    .crc_err   (crc_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        cap_data.push_back(out_data);
        cap_last.push_back(out_last);
      end
      if (done) begin
        done_cnt++;
        err_at_done = crc_err;
        crc_at_done = crc_o;
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l, input logic m);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_byte_in_ready got=%0b want=1 (timeout)", in_ready);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    mode_rx  = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int guard = 0;
    while (done_cnt < target && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (done_cnt !== target) begin
      failures++;
      $display("FAIL %s_done_count got=%0d want=%0d", name, done_cnt, target);
    end
  endtask

  task automatic clear_capture();
    cap_data.delete();
    cap_last.delete();
  endtask

  task automatic check_msg_out(input string name, input int last_idx);
    checks++;
    if (cap_data.size() != 11) begin
      failures++;
      $display("FAIL %s_byte_count got=%0d want=11", name, cap_data.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        checks++;
        if (cap_data[i] !== msg[i] || cap_last[i] !== (i == last_idx)) begin
          failures++;
          $display("FAIL %s_byte%0d got=%02h/last%0b want=%02h/last%0b",
                   name, i, cap_data[i], cap_last[i], msg[i], (i == last_idx));
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; mode_rx = 1'b0; out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    checks++; if (in_ready  !== 1'b1)     begin failures++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0)     begin failures++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    checks++; if (out_data  !== 8'h00)    begin failures++; $display("FAIL reset_out_data got=%02h want=00", out_data); end
    checks++; if (out_last  !== 1'b0)     begin failures++; $display("FAIL reset_out_last got=%0b want=0", out_last); end
    checks++; if (busy      !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%0b want=0", busy); end
    checks++; if (done      !== 1'b0)     begin failures++; $display("FAIL reset_done got=%0b want=0", done); end
    checks++; if (crc_err   !== 1'b0)     begin failures++; $display("FAIL reset_crc_err got=%0b want=0", crc_err); end
    checks++; if (crc_o     !== 16'hFFFF) begin failures++; $display("FAIL reset_crc_o got=%04h want=FFFF", crc_o); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_tx();
    int base = done_cnt;
    clear_capture();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) send_byte(msg[i], (i == 8), 1'b0);
    wait_done(base + 1, "tx");
    check_msg_out("tx", 10);
    checks++;
    if (err_at_done !== 1'b0) begin failures++; $display("FAIL tx_crc_err got=%0b want=0", err_at_done); end
  endtask

  task automatic test_rx(input logic [7:0] last_byte, input logic exp_err, input string name);
    int base = done_cnt;
    clear_capture();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send_byte(msg[i], 1'b0, 1'b1);
    send_byte(last_byte, 1'b1, 1'b1);
    wait_done(base + 1, name);
    checks++;
    if (err_at_done !== exp_err) begin failures++; $display("FAIL %s_crc_err got=%0b want=%0b", name, err_at_done, exp_err); end
    checks++;
    if (cap_data.size() != 11 || cap_last[10] !== 1'b1 || cap_data[10] !== last_byte) begin
      failures++;
      $display("FAIL %s_passthrough got=%0d bytes want=11 ending %02h with last", name, cap_data.size(), last_byte);
    end
    if (!exp_err) begin
      checks++;
      if (crc_at_done !== 16'hB001) begin failures++; $display("FAIL %s_residue got=%04h want=B001", name, crc_at_done); end
      checks++;
      if (crc_o !== 16'hB001) begin failures++; $display("FAIL %s_crc_persist got=%04h want=B001", name, crc_o); end
    end
  endtask

  task automatic test_timing();
    int base = done_cnt;
    int lat = 0;
    clear_capture();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h00; in_last = 1'b1; mode_rx = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL timing_in_ready_fall got=in_ready%0b/busy%0b want=in_ready0/busy1", in_ready, busy);
    end
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL timing_out_valid_latency got=%0d want=8 edges after accept", lat); end
    wait_done(base + 1, "timing");
    checks++;
    if (cap_data.size() != 3 || cap_data[0] !== 8'h00 || cap_data[1] !== 8'h40 || cap_data[2] !== 8'hBF ||
        cap_last[1] !== 1'b0 || cap_last[2] !== 1'b1) begin
      failures++;
      $display("FAIL timing_bytes got=%0d bytes want=00,40,BF(last)", cap_data.size());
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL timing_busy_after got=%0b want=0", busy); end
  endtask

  task automatic test_backpressure();
    int base = done_cnt;
    int guard = 0;
    clear_capture();
    out_ready = 1'b0;
    send_byte(8'hA5, 1'b1, 1'b0);
    while (!out_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_last !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_emit_hold%0d got=v%0b/%02h/l%0b/r%0b want=v1/A5/l0/r0", k, out_valid, out_data, out_last, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h80 || out_last !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_crclo_hold%0d got=v%0b/%02h/l%0b/r%0b want=v1/80/l0/r0", k, out_valid, out_data, out_last, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_done(base + 1, "bp");
    checks++;
    if (cap_data.size() != 3 || cap_data[0] !== 8'hA5 || cap_data[1] !== 8'h80 || cap_data[2] !== 8'hC4 ||
        cap_last[2] !== 1'b1) begin
      failures++;
      $display("FAIL bp_bytes got=%0d bytes want=A5,80,C4(last)", cap_data.size());
    end
  endtask

  task automatic test_reset_abort();
    int base = done_cnt;
    out_ready = 1'b1;
    send_byte(msg[0], 1'b0, 1'b0);
    send_byte(msg[1], 1'b0, 1'b0);
    send_byte(msg[2], 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || crc_err !== 1'b0 || crc_o !== 16'hFFFF) begin
      failures++;
      $display("FAIL abort_reset_values got=r%0b v%0b d%02h l%0b b%0b dn%0b e%0b crc%04h want=r1 v0 d00 l0 b0 dn0 e0 crcFFFF",
               in_ready, out_valid, out_data, out_last, busy, done, crc_err, crc_o);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    clear_capture();
    for (int i = 0; i < 9; i++) send_byte(msg[i], (i == 8), 1'b0);
    wait_done(base + 1, "abort");
    check_msg_out("abort_fresh", 10);
  endtask

  task automatic test_mode_toggle();
    int base = done_cnt;
    clear_capture();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) send_byte(msg[i], (i == 8), ((i % 2) == 1));
    wait_done(base + 1, "toggle");
    check_msg_out("toggle", 10);
    checks++;
    if (err_at_done !== 1'b0) begin failures++; $display("FAIL toggle_crc_err got=%0b want=0", err_at_done); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_tx();
    test_rx(8'hB4, 1'b0, "rx_good");
    test_rx(8'hB5, 1'b1, "rx_bad");
    test_timing();
    test_backpressure();
    test_reset_abort();
    test_mode_toggle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
